// File: rtl/qpsk_frame_serializer.sv
// Serializes a 96-bit interleaved FEC frame into 48 Gray-mapped QPSK symbols over valid/ready.
// A one-frame holding buffer lets the next frame load while the current one drains.
module qpsk_frame_serializer #(
   parameter int SYM_W = 8,
   parameter int AMP   = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_valid,
   input  logic [23:0]             word_a,
   input  logic [23:0]             word_b,
   input  logic [23:0]             word_c,
   input  logic [23:0]             word_d,
   output logic                    frame_ready,
   output logic                    sym_valid,
   input  logic                    sym_ready,
   output logic signed [SYM_W-1:0] sym_i,
   output logic signed [SYM_W-1:0] sym_q,
   output logic [5:0]              sym_idx,
   output logic                    sym_last,
   output logic                    overflow,
   input  logic                    ovf_clr
);

   localparam logic signed [SYM_W-1:0] POS      = SYM_W'(AMP);
   localparam logic signed [SYM_W-1:0] NEG      = -POS;
   localparam logic [5:0]              LAST_IDX = 6'd47;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state_q;
   logic [95:0]             active_q, hold_q;
   logic                    hold_full_q, sym_valid_q, sym_last_q, overflow_q;
   logic [5:0]              idx_q;
   logic signed [SYM_W-1:0] sym_i_q, sym_q_q;

   logic [95:0] frame_in, src_d;
   logic [5:0]  idx_d;
   logic [1:0]  dibit_d;
   logic        load, accept, last_acc, start, advance;

   function automatic logic signed [SYM_W-1:0] map_bit(input logic b);
      return b ? NEG : POS;
   endfunction

   // Next symbol comes from the active frame, or from index 0 of whichever frame starts next.
   always_comb begin
      frame_in = {word_d, word_c, word_b, word_a};
      load     = frame_valid && !hold_full_q;
      accept   = sym_valid_q && sym_ready;
      last_acc = accept && (idx_q == LAST_IDX);
      start    = ((state_q == IDLE) && load) || (last_acc && (hold_full_q || load));
      advance  = accept && (idx_q != LAST_IDX);
      src_d    = active_q;
      idx_d    = idx_q + 6'd1;
      if (start) begin
         idx_d = 6'd0;
         src_d = (last_acc && hold_full_q) ? hold_q : frame_in;
      end
      dibit_d  = src_d[{idx_d, 1'b0} +: 2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sym_valid_q <= 1'b0;
         sym_i_q     <= '0;
         sym_q_q     <= '0;
         idx_q       <= 6'd0;
         sym_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         if (frame_valid && hold_full_q) overflow_q <= 1'b1;
         else if (ovf_clr)               overflow_q <= 1'b0;

         if (start || advance) begin
            state_q     <= SEND;
            sym_valid_q <= 1'b1;
            idx_q       <= idx_d;
            sym_i_q     <= map_bit(dibit_d[0]);
            sym_q_q     <= map_bit(dibit_d[1]);
            sym_last_q  <= (idx_d == LAST_IDX);
         end else if (last_acc) begin
            state_q     <= IDLE;
            sym_valid_q <= 1'b0;
         end

         if (start) active_q <= src_d;

         if (last_acc && hold_full_q) begin
            hold_full_q <= 1'b0;
         end else if (load && !start) begin
            hold_q      <= frame_in;
            hold_full_q <= 1'b1;
         end
      end
   end

   assign frame_ready = ~hold_full_q;
   assign sym_valid   = sym_valid_q;
   assign sym_i       = sym_i_q;
   assign sym_q       = sym_q_q;
   assign sym_idx     = idx_q;
   assign sym_last    = sym_last_q;
   assign overflow    = overflow_q;

endmodule
